// File: rtl/shift_sequencer.sv
// Multi-bit shift/rotate sequencer: registers an operand and iterates a single-bit
// combinational shifter once per clock, returning result plus carry/zero flags.

module shifter #(
    parameter int SIZE = 8
) (
    input  logic [SIZE-1:0] data_in,
    input  logic            is_left_shift,
    input  logic            shift_in,
    output logic [SIZE-1:0] data_out,
    output logic            shift_out
);
    generate
        if (SIZE == 1) begin : g_one
            // A single bit simply swaps in shift_in; the old bit is what falls out.
            assign data_out  = shift_in;
            assign shift_out = data_in[0];
        end else begin : g_multi
            always_comb begin
                if (is_left_shift) begin
                    data_out  = {data_in[SIZE-2:0], shift_in};
                    shift_out = data_in[SIZE-1];
                end else begin
                    data_out  = {shift_in, data_in[SIZE-1:1]};
                    shift_out = data_in[0];
                end
            end
        end
    endgenerate
endmodule

module shift_sequencer #(
    parameter  int WIDTH = 8,
    localparam int AMT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [1:0]       op,
    input  logic [AMT_W-1:0] amount,
    input  logic [WIDTH-1:0] data_in,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero_out
);
    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // the producer holds its payload until then, and the ready side never depends on valid.
    typedef enum logic [1:0] {OP_LSL = 2'b00, OP_LSR = 2'b01, OP_ASR = 2'b10, OP_ROL = 2'b11} op_e;
    typedef enum logic [1:0] {S_IDLE = 2'b00, S_SHIFT = 2'b01, S_DONE = 2'b10} state_e;

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [AMT_W-1:0] count_q, count_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             start_ready_q, start_ready_d;
    logic             result_valid_q, result_valid_d;

    logic             sh_left;
    logic             sh_in;
    logic [WIDTH-1:0] sh_data;
    logic             sh_out;

    assign sh_left = (op_q == OP_LSL) || (op_q == OP_ROL);

    // ROL feeds back shift_out, which depends only on data_q, so there is no loop.
    always_comb begin
        sh_in = 1'b0;
        case (op_q)
            OP_ASR:  sh_in = data_q[WIDTH-1];
            OP_ROL:  sh_in = sh_out;
            default: sh_in = 1'b0;
        endcase
    end

    shifter #(.SIZE(WIDTH)) u_shifter (
        .data_in       (data_q),
        .is_left_shift (sh_left),
        .shift_in      (sh_in),
        .data_out      (sh_data),
        .shift_out     (sh_out)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        count_d = count_q;
        carry_d = carry_q;
        case (state_q)
            S_IDLE: begin
                if (start_valid) begin
                    data_d  = data_in;
                    op_d    = op_e'(op);
                    count_d = amount;
                    carry_d = 1'b0;
                    state_d = (amount == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                data_d  = sh_data;
                carry_d = sh_out;
                count_d = count_q - AMT_W'(1);
                if (count_q == AMT_W'(1)) state_d = S_DONE;
            end
            S_DONE: begin
                if (result_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        start_ready_d  = (state_d == S_IDLE);
        result_valid_d = (state_d == S_DONE);
        zero_d         = (data_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            op_q           <= OP_LSL;
            data_q         <= '0;
            count_q        <= '0;
            carry_q        <= 1'b0;
            zero_q         <= 1'b1;
            start_ready_q  <= 1'b1;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            data_q         <= data_d;
            count_q        <= count_d;
            carry_q        <= carry_d;
            zero_q         <= zero_d;
            start_ready_q  <= start_ready_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign start_ready  = start_ready_q;
    assign result_valid = result_valid_q;
    assign result       = data_q;
    assign carry_out    = carry_q;
    assign zero_out     = zero_q;
endmodule
